// File: rtl/ext_int_ctl.sv
// External interrupt controller: level/edge sources, priority arbitration, claim/complete.
// Latency: level src high -> exti high after 2 clock edges; register reads are combinational.
module ext_int_ctl #(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_SRC-1:0] src,
    input  logic [5:0]         reg_addr,
    input  logic               reg_read,
    input  logic               reg_write,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               exti
);
    localparam int ID_W = $clog2(NUM_SRC + 1);

    logic [NUM_SRC-1:0] r_src_q;
    logic [NUM_SRC:1]   r_pending;
    logic [NUM_SRC:1]   r_in_service;
    logic [NUM_SRC:1]   r_enable;
    logic [NUM_SRC:1]   r_edge;
    logic [PRIO_W-1:0]  r_threshold;
    logic [PRIO_W-1:0]  r_prio [1:NUM_SRC];
    logic [ID_W-1:0]    r_best_id;
    logic               r_exti;

    logic [ID_W-1:0]    w_arb_id;
    logic [PRIO_W-1:0]  w_arb_prio;
    logic [ID_W-1:0]    w_claim_id;
    logic               w_claim_fire;
    logic               w_complete;
    logic [NUM_SRC:1]   w_pending_nxt;
    logic [NUM_SRC:1]   w_in_service_nxt;

    // Ascending scan with strict '>' gives ties to the lowest ID; prio > threshold implies prio != 0.
    always_comb begin
        w_arb_id   = '0;
        w_arb_prio = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if (r_pending[i] && r_enable[i] && (r_prio[i] > r_threshold) && (r_prio[i] > w_arb_prio)) begin
                w_arb_id   = ID_W'(i);
                w_arb_prio = r_prio[i];
            end
        end
    end

    // best_id can be one cycle stale after a claim, so qualify it with the live pending bit.
    always_comb begin
        w_claim_id = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            if ((r_best_id == ID_W'(i)) && r_pending[i]) begin
                w_claim_id = r_best_id;
            end
        end
    end

    assign w_claim_fire = reg_read && (reg_addr == 6'h00) && (w_claim_id != '0);
    assign w_complete   = reg_write && (reg_addr == 6'h00);

    // Edge set beats a claim clear; a claim suppresses the level re-set in its own cycle.
    always_comb begin
        w_pending_nxt    = '0;
        w_in_service_nxt = '0;
        for (int i = 1; i <= NUM_SRC; i++) begin
            w_pending_nxt[i] = (r_edge[i] && src[i-1] && !r_src_q[i-1])
                             || ((r_pending[i] || (!r_edge[i] && src[i-1] && !r_in_service[i]))
                                 && !(w_claim_fire && (w_claim_id == ID_W'(i))));
            w_in_service_nxt[i] = (r_in_service[i] || (w_claim_fire && (w_claim_id == ID_W'(i))))
                                && !(w_complete && (reg_wdata == 32'(i)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_src_q      <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_enable     <= '0;
            r_edge       <= '0;
            r_threshold  <= '0;
            r_best_id    <= '0;
            r_exti       <= 1'b0;
            for (int i = 1; i <= NUM_SRC; i++) begin
                r_prio[i] <= '0;
            end
        end else begin
            r_src_q      <= src;
            r_pending    <= w_pending_nxt;
            r_in_service <= w_in_service_nxt;
            r_best_id    <= w_arb_id;
            r_exti       <= (w_arb_id != '0);
            if (reg_write) begin
                case (reg_addr)
                    6'h01:   r_threshold <= reg_wdata[PRIO_W-1:0];
                    6'h02:   r_enable    <= reg_wdata[NUM_SRC:1];
                    6'h03:   r_edge      <= reg_wdata[NUM_SRC:1];
                    default: ;
                endcase
                for (int i = 1; i <= NUM_SRC; i++) begin
                    if (reg_addr == 6'(32 + i)) begin
                        r_prio[i] <= reg_wdata[PRIO_W-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (reg_addr)
            6'h00:   reg_rdata = 32'(w_claim_id);
            6'h01:   reg_rdata = 32'(r_threshold);
            6'h02:   reg_rdata = 32'({r_enable, 1'b0});
            6'h03:   reg_rdata = 32'({r_edge, 1'b0});
            6'h04:   reg_rdata = 32'({r_pending, 1'b0});
            default: begin
                for (int i = 1; i <= NUM_SRC; i++) begin
                    if (reg_addr == 6'(32 + i)) begin
                        reg_rdata = 32'(r_prio[i]);
                    end
                end
            end
        endcase
    end

    assign exti = r_exti;

endmodule

// File: tb/tb_ext_int_ctl.sv
// Directed bench for ext_int_ctl with a scoreboard queue of expected values.
module tb_ext_int_ctl;
    logic        clk;
    logic        rst_n;
    logic [7:0]  src;
    logic [5:0]  reg_addr;
    logic        reg_read;
    logic        reg_write;
    logic [31:0] reg_wdata;
    logic [31:0] reg_rdata;
    logic        exti;

    int n_pass  = 0;
    int n_total = 0;

    string       tag_q[$];
    logic [31:0] val_q[$];

    ext_int_ctl #(.NUM_SRC(8), .PRIO_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .src       (src),
        .reg_addr  (reg_addr),
        .reg_read  (reg_read),
        .reg_write (reg_write),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .exti      (exti)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        val_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_total++;
        if (val_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %0h required an expected entry", obs);
        end else begin
            t = tag_q.pop_front();
            e = val_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %0h required %0h", t, obs, e);
        end
    endtask

    task automatic wr(input logic [5:0] a, input logic [31:0] d);
        reg_addr  = a;
        reg_wdata = d;
        reg_write = 1'b1;
        tick();
        reg_write = 1'b0;
        reg_wdata = '0;
    endtask

    task automatic rd(input logic [5:0] a, input logic [31:0] e, input string t);
        reg_addr = a;
        push_exp(t, e);
        #1;
        check(reg_rdata);
    endtask

    task automatic claim(input logic [31:0] e, input string t);
        reg_addr = 6'h00;
        reg_read = 1'b1;
        push_exp(t, e);
        #1;
        check(reg_rdata);
        tick();
        reg_read = 1'b0;
    endtask

    task automatic chk_exti(input logic e, input string t);
        push_exp(t, {31'b0, e});
        check({31'b0, exti});
    endtask

    task automatic do_reset();
        src   = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; src = '0; reg_addr = '0;
        reg_read = 1'b0; reg_write = 1'b0; reg_wdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk_exti(1'b0, "rst_exti");
        rd(6'h00, 32'h0, "rst_claim");
        rd(6'h01, 32'h0, "rst_threshold");
        rd(6'h02, 32'h0, "rst_enable");
        tick();
        rd(6'h03, 32'h0, "rst_edge");
        rd(6'h04, 32'h0, "rst_pending");
        rd(6'h21, 32'h0, "rst_prio1");

        // Field truncation and unmapped addresses
        wr(6'h02, 32'hFFFF_FFFF);
        rd(6'h02, 32'h0000_01FE, "enable_bit0_masked");
        wr(6'h03, 32'hFFFF_FFFF);
        rd(6'h03, 32'h0000_01FE, "edge_bit0_masked");
        wr(6'h01, 32'h0000_00FF);
        rd(6'h01, 32'h0000_0007, "threshold_trunc");
        wr(6'h21, 32'h0000_000F);
        rd(6'h21, 32'h0000_0007, "prio_trunc");
        wr(6'h29, 32'h0000_0005);
        rd(6'h29, 32'h0, "prio9_unmapped");
        rd(6'h20, 32'h0, "prio0_unmapped");
        rd(6'h05, 32'h0, "addr5_unmapped");
        do_reset();

        // Single level source, claim, stale claim, complete while still high
        wr(6'h23, 32'd2);
        wr(6'h02, 32'h08);
        src = 8'h04;
        tick();
        chk_exti(1'b0, "lvl_exti_1cyc");
        rd(6'h04, 32'h08, "lvl_pending");
        tick();
        chk_exti(1'b1, "lvl_exti_2cyc");
        claim(32'd3, "lvl_claim3");
        rd(6'h00, 32'h0, "lvl_claim_stale");
        tick();
        chk_exti(1'b0, "lvl_exti_after_claim");
        rd(6'h00, 32'h0, "lvl_claim_empty");
        rd(6'h04, 32'h0, "lvl_pending_in_service");
        wr(6'h00, 32'd3);
        chk_exti(1'b0, "lvl_exti_at_complete");
        tick();
        rd(6'h04, 32'h08, "lvl_repend");
        tick();
        chk_exti(1'b1, "lvl_exti_reassert");
        claim(32'd3, "lvl_claim3_again");
        do_reset();

        // Priority order and tie break
        wr(6'h21, 32'd4);
        wr(6'h22, 32'd4);
        wr(6'h25, 32'd6);
        wr(6'h02, 32'h26);
        src = 8'h13;
        tick(); tick();
        chk_exti(1'b1, "prio_exti");
        claim(32'd5, "prio_claim5");
        tick();
        claim(32'd1, "prio_claim1");
        tick();
        claim(32'd2, "prio_claim2");
        tick();
        claim(32'd0, "prio_claim0");
        chk_exti(1'b0, "prio_exti_done");
        do_reset();

        // Threshold gating
        wr(6'h21, 32'd2);
        wr(6'h01, 32'd2);
        wr(6'h02, 32'h02);
        src = 8'h01;
        tick(); tick(); tick();
        chk_exti(1'b0, "thr_blocked");
        wr(6'h01, 32'd1);
        chk_exti(1'b0, "thr_write_edge");
        tick();
        chk_exti(1'b1, "thr_released");
        do_reset();

        // Edge mode
        wr(6'h03, 32'h10);
        wr(6'h02, 32'h10);
        wr(6'h24, 32'd1);
        src = 8'h08;
        tick();
        src = 8'h00;
        rd(6'h04, 32'h10, "edge_pend");
        tick();
        chk_exti(1'b1, "edge_exti");
        claim(32'd4, "edge_claim4");
        rd(6'h04, 32'h0, "edge_pend_cleared");
        src = 8'h08;
        tick();
        src = 8'h00;
        rd(6'h04, 32'h10, "edge_pend_in_service");
        tick();
        src = 8'h08;
        claim(32'd4, "edge_claim4_again");
        src = 8'h00;
        rd(6'h04, 32'h10, "edge_set_wins");
        do_reset();

        // Bad complete, then reset with an interrupt in service
        wr(6'h22, 32'd3);
        wr(6'h02, 32'h04);
        src = 8'h02;
        tick(); tick();
        chk_exti(1'b1, "bad_exti");
        claim(32'd2, "bad_claim2");
        tick();
        wr(6'h00, 32'd7);
        wr(6'h00, 32'h0000_0102);
        tick();
        rd(6'h04, 32'h0, "bad_complete_ignored");
        chk_exti(1'b0, "bad_exti_low");
        do_reset();
        rd(6'h04, 32'h0, "rst2_pending");
        chk_exti(1'b0, "rst2_exti");
        rd(6'h00, 32'h0, "rst2_claim");
        rd(6'h22, 32'h0, "rst2_prio2");
        rd(6'h02, 32'h0, "rst2_enable");
        tick();
        wr(6'h22, 32'd3);
        wr(6'h02, 32'h04);
        src = 8'h02;
        tick(); tick();
        chk_exti(1'b1, "rst2_no_complete_needed");
        claim(32'd2, "rst2_claim2");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
